// File: rtl/mem_initiator_if.sv
// Host request/response channels and memory bus of the memory initiator.
// The master modport is the initiator's own view; the slave modport is the
// view of whoever sits on the other side (host plus memory).
interface mem_initiator_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8
);
   // host request channel
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_wr;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   // host response channel
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_wr;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   // memory side
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_wr_en;
   logic                  mem_rd_en;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   // status
   logic [15:0]           txn_count;

   modport master (
      input  req_valid, req_wr, req_addr, req_wdata,
      output req_ready,
      output rsp_valid, rsp_wr, rsp_rdata,
      input  rsp_ready,
      output mem_addr, mem_wr_en, mem_rd_en, mem_wdata,
      input  mem_rdata,
      output txn_count
   );

   modport slave (
      output req_valid, req_wr, req_addr, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_wr, rsp_rdata,
      output rsp_ready,
      input  mem_addr, mem_wr_en, mem_rd_en, mem_wdata,
      output mem_rdata,
      input  txn_count
   );
endinterface

// File: rtl/mem_initiator.sv
// Single-transaction initiator for a single-port synchronous memory.
// A host request is accepted in IDLE, issued to the memory for one cycle,
// (for reads) waited on for RD_LAT cycles, and returned as a response that
// is held until the host takes it. Every output is driven straight from a
// flop; the output process computes the next value of each output register.
module mem_initiator #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LAT     = 1
) (
   input  logic          clk,
   input  logic          reset,
   mem_initiator_if.master bus
);

   localparam int CNT_W = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t                state_q,     state_d;
   logic                  req_wr_q,    req_wr_d;
   logic [CNT_W-1:0]      wait_cnt_q,  wait_cnt_d;
   logic                  req_ready_q, req_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_wr_q,    rsp_wr_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
   logic                  mem_wr_en_q, mem_wr_en_d;
   logic                  mem_rd_en_q, mem_rd_en_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [15:0]           txn_count_q, txn_count_d;

   logic                  req_fire_s;
   logic                  rsp_fire_s;
   logic                  wait_done_s;

   // Handshake events; acceptance relies on the registered ready so a request
   // seen during RESP can never be taken, even on the response edge.
   assign req_fire_s  = (state_q == ST_IDLE) && bus.req_valid && req_ready_q;
   assign rsp_fire_s  = (state_q == ST_RESP) && rsp_valid_q && bus.rsp_ready;
   assign wait_done_s = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(1));

   // State and output registers; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         req_wr_q    <= 1'b0;
         wait_cnt_q  <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_wr_q    <= 1'b0;
         rsp_rdata_q <= '0;
         mem_addr_q  <= '0;
         mem_wr_en_q <= 1'b0;
         mem_rd_en_q <= 1'b0;
         mem_wdata_q <= '0;
         txn_count_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         req_wr_q    <= req_wr_d;
         wait_cnt_q  <= wait_cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_wr_q    <= rsp_wr_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wr_en_q <= mem_wr_en_d;
         mem_rd_en_q <= mem_rd_en_d;
         mem_wdata_q <= mem_wdata_d;
         txn_count_q <= txn_count_d;
      end
   end

   // Next-state selection for the IDLE -> ISSUE -> (WAIT) -> RESP loop.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_fire_s) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (req_wr_q) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wait_done_s) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (rsp_fire_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the output registers; strobes are set on the accept edge
   // so they are high exactly during the ISSUE cycle.
   always_comb begin
      req_wr_d    = req_wr_q;
      wait_cnt_d  = wait_cnt_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_wr_d    = rsp_wr_q;
      rsp_rdata_d = rsp_rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wr_en_d = 1'b0;
      mem_rd_en_d = 1'b0;
      mem_wdata_d = mem_wdata_q;
      txn_count_d = txn_count_q;
      case (state_q)
         ST_IDLE: begin
            if (req_fire_s) begin
               // latch the request; later host input changes cannot reach the bus
               req_ready_d = 1'b0;
               req_wr_d    = bus.req_wr;
               mem_addr_d  = bus.req_addr;
               mem_wr_en_d = bus.req_wr;
               mem_rd_en_d = !bus.req_wr;
               if (bus.req_wr) begin
                  mem_wdata_d = bus.req_wdata;
               end else begin
                  mem_wdata_d = mem_wdata_q;
               end
            end else begin
               req_ready_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (req_wr_q) begin
               rsp_valid_d = 1'b1;
               rsp_wr_d    = 1'b1;
               rsp_rdata_d = '0;
            end else begin
               wait_cnt_d  = CNT_W'(RD_LAT);
            end
         end
         ST_WAIT: begin
            if (wait_done_s) begin
               // memory data is valid on the last wait edge
               rsp_valid_d = 1'b1;
               rsp_wr_d    = 1'b0;
               rsp_rdata_d = bus.mem_rdata;
               wait_cnt_d  = '0;
            end else begin
               wait_cnt_d  = wait_cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_fire_s) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               txn_count_d = txn_count_q + 16'd1;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_wr    = rsp_wr_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wr_en = mem_wr_en_q;
   assign bus.mem_rd_en = mem_rd_en_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.txn_count = txn_count_q;

endmodule
